// File: rtl/bcd_digit_setter.sv
// Editable BCD digit vector driven by inc/dec buttons with hold-to-repeat.
// Steps one selected digit with wrap, no carry; parallel load overrides edits.
module bcd_digit_setter #(
  parameter int NUM_DIGITS   = 4,
  parameter int MMSS_MODE    = 0,
  parameter int REPEAT_DELAY = 50000000,
  parameter int REPEAT_RATE  = 10000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    inc_btn,
  input  logic                    dec_btn,
  input  logic [2:0]              sel,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  output logic [4*NUM_DIGITS-1:0] big_bin,
  output logic                    step_pulse
);

  localparam int W = 4 * NUM_DIGITS;
  localparam int MAXC = (REPEAT_DELAY > REPEAT_RATE)
                      ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] DLY_LD = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RPT_LD = CW'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT,
    LOCKOUT
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            act_up;
  logic            prev_inc;
  logic            prev_dec;

  logic            one_btn;
  logic            both_btn;
  logic            start;
  logic            held;
  logic            cnt_zero;
  logic            sel_ok;
  logic            step_req;
  logic            step_up;
  logic            apply;
  logic [W-1:0]    big_next;

  function automatic logic [3:0] digit_limit(input int idx);
    if (MMSS_MODE != 0 && (idx == 1 || idx == 3))
      return 4'd5;
    return 4'd9;
  endfunction

  // Out-of-range digits (only reachable via load) snap to 0 or limit.
  function automatic logic [3:0] step_digit(
    input logic [3:0] d,
    input logic [3:0] lim,
    input logic       up
  );
    logic [3:0] r;
    if (up) begin
      if (d >= lim) r = 4'd0;
      else          r = d + 4'd1;
    end else begin
      if (d == 4'd0 || d > lim) r = lim;
      else                      r = d - 4'd1;
    end
    return r;
  endfunction

  assign one_btn  = inc_btn ^ dec_btn;
  assign both_btn = inc_btn & dec_btn;
  assign start    = enable & one_btn &
                    ((inc_btn & ~prev_inc) | (dec_btn & ~prev_dec));
  assign held     = enable & one_btn & (inc_btn == act_up);
  assign cnt_zero = (cnt == '0);
  assign sel_ok   = (int'(sel) < NUM_DIGITS);
  assign apply    = step_req & sel_ok & ~load;

  always_comb begin
    step_req = 1'b0;
    step_up  = act_up;
    unique case (state)
      IDLE: begin
        step_req = start;
        step_up  = inc_btn;
      end
      DELAY, REPEAT: step_req = held & cnt_zero;
      default: step_req = 1'b0;
    endcase
  end

  always_comb begin
    big_next = big_bin;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (int'(sel) == i)
        big_next[4*i +: 4] = step_digit(big_bin[4*i +: 4],
                                        digit_limit(i), step_up);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      act_up     <= 1'b0;
      prev_inc   <= 1'b0;
      prev_dec   <= 1'b0;
      big_bin    <= '0;
      step_pulse <= 1'b0;
    end else begin
      prev_inc   <= inc_btn;
      prev_dec   <= dec_btn;
      step_pulse <= apply;
      if (apply)
        big_bin <= big_next;
      if (load) begin
        big_bin <= load_value;
        state   <= LOCKOUT;
        cnt     <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (both_btn) begin
              state <= LOCKOUT;
            end else if (start) begin
              state  <= DELAY;
              cnt    <= DLY_LD;
              act_up <= inc_btn;
            end
          end
          DELAY, REPEAT: begin
            if (!held) begin
              state <= LOCKOUT;
              cnt   <= '0;
            end else if (cnt_zero) begin
              state <= REPEAT;
              cnt   <= RPT_LD;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
          LOCKOUT: begin
            if (!inc_btn && !dec_btn)
              state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bcd_digit_setter.sv
// Scoreboard bench for bcd_digit_setter: press-level reference model,
// expected digit vectors queued per step and popped on step_pulse.
module tb_bcd_digit_setter;

  localparam int ND   = 4;
  localparam int DLY  = 4;
  localparam int RATE = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inc_btn = 1'b0;
  logic        dec_btn = 1'b0;
  logic [2:0]  sel = 3'd0;
  logic        enable = 1'b1;
  logic        load = 1'b0;
  logic [15:0] load_value = 16'h0;
  logic [15:0] big_bin;
  logic        step_pulse;

  int n_chk = 0;
  int n_fail = 0;
  int n_pulse = 0;
  int p0;
  logic [15:0] exp_q[$];
  int m[ND];

  bcd_digit_setter #(
    .NUM_DIGITS  (ND),
    .MMSS_MODE   (1),
    .REPEAT_DELAY(DLY),
    .REPEAT_RATE (RATE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .inc_btn   (inc_btn),
    .dec_btn   (dec_btn),
    .sel       (sel),
    .enable    (enable),
    .load      (load),
    .load_value(load_value),
    .big_bin   (big_bin),
    .step_pulse(step_pulse)
  );

  always #5 clk = ~clk;

  function automatic int lim_of(int i);
    return (i == 1 || i == 3) ? 5 : 9;
  endfunction

  function automatic logic [15:0] model_vec();
    logic [15:0] r;
    r = 16'h0;
    for (int i = 0; i < ND; i++) r[4*i +: 4] = 4'(m[i]);
    return r;
  endfunction

  function automatic bit on_schedule(int k);
    return k == 0 || (k >= DLY && (k - DLY) % RATE == 0);
  endfunction

  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mstep(bit up, int idx);
    int d, l;
    if (idx >= ND) return;
    d = m[idx];
    l = lim_of(idx);
    if (up) m[idx] = (d > l) ? 0 : (d + 1) % (l + 1);
    else    m[idx] = (d > l) ? l : (d + l) % (l + 1);
    exp_q.push_back(model_vec());
  endtask

  task automatic set_model(logic [15:0] v);
    for (int i = 0; i < ND; i++) m[i] = int'((v >> (4 * i)) & 16'hF);
  endtask

  task automatic press(bit up, int s0, int s1, int sw, int hold, int drop);
    for (int k = 0; k < hold; k++) begin
      inc_btn = up;
      dec_btn = !up;
      enable  = (k < drop);
      sel     = 3'((k < sw) ? s0 : s1);
      if (k < drop && on_schedule(k)) mstep(up, (k < sw) ? s0 : s1);
      tick();
    end
    inc_btn = 1'b0;
    dec_btn = 1'b0;
    enable  = 1'b1;
    repeat (3) tick();
  endtask

  task automatic both_press(int s, int hold);
    inc_btn = 1'b1;
    dec_btn = 1'b1;
    sel     = 3'(s);
    repeat (hold) tick();
    inc_btn = 1'b0;
    dec_btn = 1'b0;
    repeat (3) tick();
  endtask

  task automatic do_load(logic [15:0] v);
    load       = 1'b1;
    load_value = v;
    tick();
    load = 1'b0;
    set_model(v);
    tick();
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (!rst && step_pulse) begin
          n_pulse++;
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_step: got pulse, big_bin=%h, required none",
                     big_bin);
          end else begin
            chk("step_value", big_bin, exp_q.pop_front());
          end
        end
      end
    join_none

    for (int i = 0; i < ND; i++) m[i] = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_big_bin", big_bin, 16'h0000);
    chk("reset_pulse", {15'b0, step_pulse}, 16'h0);
    rst = 1'b0;
    tick();

    p0 = n_pulse;
    press(1, 0, 0, 99, 3, 99);
    chk("single_inc", big_bin, 16'h0001);
    chk("single_inc_pulses", 16'(n_pulse - p0), 16'd1);

    do_load(16'h0050);
    chk("load_0050", big_bin, 16'h0050);
    press(1, 1, 1, 99, 2, 99);
    chk("mmss_wrap_up", big_bin, 16'h0000);
    press(0, 1, 1, 99, 2, 99);
    chk("mmss_wrap_down", big_bin, 16'h0050);

    do_load(16'h0000);
    p0 = n_pulse;
    press(1, 0, 0, 99, 11, 99);
    chk("repeat_value", big_bin, 16'h0005);
    chk("repeat_pulses", 16'(n_pulse - p0), 16'd5);

    do_load(16'h0000);
    both_press(2, 3);
    chk("both_no_change", big_bin, 16'h0000);
    press(0, 2, 2, 99, 3, 99);
    chk("dec_sel2", big_bin, 16'h0900);

    do_load(16'h0000);
    p0 = n_pulse;
    inc_btn    = 1'b1;
    sel        = 3'd0;
    load       = 1'b1;
    load_value = 16'h1234;
    tick();
    load = 1'b0;
    set_model(16'h1234);
    repeat (6) tick();
    chk("load_over_step", big_bin, 16'h1234);
    inc_btn = 1'b0;
    repeat (3) tick();
    chk("load_no_pulse", 16'(n_pulse - p0), 16'd0);
    press(1, 0, 0, 99, 2, 99);
    chk("after_load_press", big_bin, 16'h1235);

    do_load(16'h0000);
    press(1, 0, 2, 5, 9, 99);
    chk("sel_redirect", big_bin, 16'h0202);

    do_load(16'hFAC7);
    press(1, 3, 3, 99, 1, 99);
    press(0, 2, 2, 99, 1, 99);
    press(0, 1, 1, 99, 1, 99);
    chk("invalid_digits", big_bin, 16'h0957);

    do_load(16'h4321);
    p0 = n_pulse;
    press(1, 6, 6, 99, 6, 99);
    chk("bad_sel_value", big_bin, 16'h4321);
    chk("bad_sel_pulses", 16'(n_pulse - p0), 16'd0);

    do_load(16'h0000);
    press(1, 0, 0, 99, 10, 5);
    chk("enable_drop", big_bin, 16'h0002);

    do_load(16'h0000);
    inc_btn = 1'b1;
    dec_btn = 1'b0;
    sel     = 3'd0;
    for (int k = 0; k < 7; k++) begin
      if (on_schedule(k)) mstep(1, 0);
      tick();
    end
    #6;
    rst = 1'b1;
    #1;
    chk("async_reset_bin", big_bin, 16'h0000);
    chk("async_reset_pulse", {15'b0, step_pulse}, 16'h0);
    set_model(16'h0000);
    #1;
    rst = 1'b0;
    mstep(1, 0);
    tick();
    inc_btn = 1'b0;
    repeat (3) tick();
    chk("held_through_reset", big_bin, 16'h0001);

    repeat (150) begin
      int r, hold;
      r    = $urandom_range(0, 9);
      hold = $urandom_range(1, 14);
      if (r == 0) begin
        do_load(16'($urandom));
      end else if (r == 1) begin
        both_press($urandom_range(0, 6), hold);
      end else begin
        press(bit'($urandom_range(0, 1)),
              $urandom_range(0, 5), $urandom_range(0, 5),
              $urandom_range(0, 14), hold,
              ($urandom_range(0, 3) == 0) ? $urandom_range(0, hold) : hold);
      end
      chk("random_state", big_bin, model_vec());
    end

    chk("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
